uart_rx_fifo: RTL and testbench

Serial UART receiver with glitch-filtered start detection and a byte FIFO, sitting behind the SoC `uart_rx` pin and feeding the CPU-side UART register block. It accepts 8N1 frames (optionally 8E1), rejects short low pulses on an idle line, and buffers received bytes until the bus side pops them. Framing, parity and overrun conditions are reported as sticky flags.

---
 rtl/uart_rx_fifo.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with glitch-filtered start detection,
// feeding a byte FIFO that the bus side drains with a valid/ready pop.
// The receiver and the FIFO run on a single clock domain with an
// asynchronous active-low reset.
// Framing, parity and overrun problems are kept as sticky flags until
// clr_err is pulsed.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames, PARITY state present, parity_err live
//   undefined -> 8N1 frames, no parity logic, parity_err tied to 0
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rx,
    output logic [7:0]                    rdata,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          clr_err
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    // Counter reload values: a full bit period, and the half period that
    // moves the first sample into the middle of the start bit.
    localparam logic [CW-1:0] C_FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_BIT = CW'(HALF_BIT - 1);
    localparam logic [AW:0]   C_DEPTH    = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Receiver state encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    // Synchronizer and edge detection
    logic          r_rx_meta;
    logic          r_rx_s;
    logic [1:0]    r_sync_fill;
    logic          r_rx_prev;
    logic          w_fall;

    // Receiver
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_push;
    logic [7:0]    r_push_data;
    logic          r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic          r_parity_err;
`endif

    // FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;

    // ------------------------------------------------------------------
    // Two-flop synchronizer on rx, plus a fill marker so that the reset
    // value of the synchronizer (idle high) is never mistaken for a real
    // line level. A line that is low when reset releases therefore has to
    // go high and fall again before a start bit is recognised.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_sync_fill <= 2'b00;
            r_rx_prev   <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_rx_prev   <= r_sync_fill[1] & r_rx_s;
        end
    end

    // A start candidate is a genuine 1->0 transition of the synced line.
    assign w_fall = r_rx_prev & ~r_rx_s;

    // ------------------------------------------------------------------
    // Receiver FSM: finds the start bit, samples each bit in its middle,
    // checks parity (optional) and the stop bit, and hands a good byte to
    // the FIFO one cycle after the stop sample.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push <= 1'b0;

            // Clear first; a set later in this block wins if both happen
            // in the same cycle.
            if (clr_err) begin
                r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= C_HALF_BIT;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt == '0) begin
                        if (!r_rx_s) begin
                            r_cnt     <= C_FULL_BIT;
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            // Low pulse shorter than half a bit: ignore it.
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_cnt   <= C_FULL_BIT;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == '0) begin
                        // Even parity: data bits plus parity bit hold an
                        // even number of ones. The byte is kept either way.
                        if (r_rx_s != (^r_shift)) begin
                            r_parity_err <= 1'b1;
                        end
                        r_cnt   <= C_FULL_BIT;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (r_cnt == '0) begin
                        if (r_rx_s) begin
                            r_push      <= 1'b1;
                            r_push_data <= r_shift;
                            r_state     <= S_IDLE;
                        end else begin
                            // Missing stop bit: drop the byte and wait for
                            // the line to recover before hunting again.
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = rready & ~w_empty;
    // When full, a push is still accepted if the head leaves in the same
    // cycle: the write lands in the slot being freed.
    assign w_wr_en = r_push & (~w_full | w_pop);
    assign w_drop  = r_push & w_full & ~w_pop;

    // Storage array, written without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    // Pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head byte is read combinationally and forced to 0 while empty so the
    // bus never sees stale RAM contents.
    assign rdata     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign rvalid    = ~w_empty;
    assign count     = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a scoreboard of expected bytes is filled when
// frames are sent; a monitor pops and compares whenever the DUT hands out
// a byte (rvalid & rready). Set UART_RX_PARITY_EN to exercise 8E1 frames.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 1000000;
    localparam int DEPTH    = 16;
    localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON  = 1'b1;
    localparam int FRAME_BITS = 11;
`else
    localparam bit PARITY_ON  = 1'b0;
    localparam int FRAME_BITS = 10;
`endif
    // Push edge counted from the falling start edge: sync delay, half a
    // bit to the start sample, one bit per remaining sample, then push.
    localparam int LAT_LO = CPB * (FRAME_BITS - 1) + CPB / 2 - 15;
    localparam int LAT_HI = CPB * (FRAME_BITS - 1) + CPB / 2 + 25;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic [4:0] count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       clr_err;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rready     (rready),
        .count      (count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    bit         exp_frame   = 1'b0;
    bit         exp_parity  = 1'b0;
    bit         exp_overrun = 1'b0;
    bit         rand_rdy    = 1'b0;
    int         lat         = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    // Monitor: every accepted pop must match the scoreboard head.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstn && rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=0x%02h required=none", rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_rdata", {24'd0, rdata}, {24'd0, e});
                end
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // One clock step; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rready = 1'($urandom_range(0, 1));
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) tick();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Reference model: a good frame adds its byte unless the FIFO is full
    // with no pop coinciding with the push; a bad stop bit drops the byte
    // and raises frame_err; a flipped parity bit raises parity_err in 8E1.
    task automatic send_frame(input logic [7:0] d, input bit stop_v,
                              input bit par_flip, input bit pop_at_push);
        logic pbit;
        pbit = (^d) ^ par_flip;
        if (stop_v) begin
            if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back(d);
            else exp_overrun = 1'b1;
        end else begin
            exp_frame = 1'b1;
        end
        exp_parity = exp_parity | (par_flip & PARITY_ON);

        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (PARITY_ON) bit_out(pbit);
        bit_out(stop_v);
        rx = 1'b1;
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (int'(count) != target && n < budget) begin
            tick();
            n++;
        end
        chk(name, {27'd0, count}, target);
    endtask

    task automatic drain(input string name);
        rready = 1'b1;
        wait_count(0, 200, name);
        rready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        rx      = 1'b1;
        rready  = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset state
        chk("reset_rvalid", {31'd0, rvalid}, 0);
        chk("reset_count", {27'd0, count}, 0);
        chk("reset_rdata", {24'd0, rdata}, 0);
        chk("reset_frame_err", {31'd0, frame_err}, 0);
        chk("reset_parity_err", {31'd0, parity_err}, 0);
        chk("reset_overrun", {31'd0, overrun}, 0);
        idle(10);

        // Single byte 0xA5, measure push latency from the start edge
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
            begin
                lat = 0;
                while (count != 5'd1 && lat < 3000) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        $display("info a5 latency=%0d", lat);
        chk("a5_latency_in_window", {31'd0, (lat >= LAT_LO && lat <= LAT_HI)}, 1);
        chk("a5_count", {27'd0, count}, 1);
        chk("a5_rdata", {24'd0, rdata}, 8'hA5);
        drain("a5_pop_count");
        chk("empty_rdata", {24'd0, rdata}, 0);
        idle(5);

        // Short low glitch on an idle line
        rx = 1'b0;
        repeat (30) tick();
        idle(300);
        chk("glitch_count", {27'd0, count}, 0);
        chk("glitch_frame_err", {31'd0, frame_err}, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("after_glitch_count", {27'd0, count}, 1);
        drain("after_glitch_drain");

        // Framing error, then recovery
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(20);
        chk("ferr_count", {27'd0, count}, 0);
        chk("ferr_flag", {31'd0, frame_err}, {31'd0, exp_frame});
        pulse_clr();
        exp_frame = 1'b0;
        chk("ferr_cleared", {31'd0, frame_err}, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("ferr_next_count", {27'd0, count}, 1);
        drain("ferr_next_drain");

        // 17 bytes without popping: 16 kept, last dropped
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            idle(3);
        end
        chk("ovr_count", {27'd0, count}, 16);
        chk("ovr_flag", {31'd0, overrun}, {31'd0, exp_overrun});
        pulse_clr();
        exp_overrun = 1'b0;
        chk("ovr_cleared", {31'd0, overrun}, 0);

        // Full FIFO, pop exactly on the push edge of a new byte
        fork
            send_frame(8'h55, 1'b1, 1'b0, 1'b1);
            begin
                repeat (lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                rready = 1'b1;
                @(posedge clk);
                #1;
                rready = 1'b0;
            end
        join
        idle(5);
        chk("pushpop_count", {27'd0, count}, 16);
        chk("pushpop_overrun", {31'd0, overrun}, 0);
        drain("pushpop_drain");

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 needs parity bit 1 for even parity
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(5);
        chk("par_bad_count", {27'd0, count}, 1);
        chk("par_bad_flag", {31'd0, parity_err}, 1);
        drain("par_bad_drain");
        pulse_clr();
        exp_parity = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("par_good_flag", {31'd0, parity_err}, 0);
        drain("par_good_drain");
`endif

        // Randomized frames with random popping
        pulse_clr();
        exp_frame = 1'b0; exp_parity = 1'b0; exp_overrun = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            bit stop_v, flip;
            d      = 8'($urandom_range(0, 255));
            stop_v = (i == 3) ? 1'b0 : ($urandom_range(0, 5) != 0);
            flip   = ($urandom_range(0, 4) == 0);
            send_frame(d, stop_v, flip, 1'b0);
            idle($urandom_range(5, 40));
        end
        rand_rdy = 1'b0;
        drain("rand_drain");
        chk("rand_frame_err", {31'd0, frame_err}, {31'd0, exp_frame});
        chk("rand_parity_err", {31'd0, parity_err}, {31'd0, exp_parity});
        chk("rand_overrun", {31'd0, overrun}, {31'd0, exp_overrun});

        // Reset in the middle of a frame with the line held low
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(3);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("pre_reset_count", {27'd0, count}, 2);
        rx = 1'b0;
        repeat (400) tick();
        rstn = 1'b0;
        exp_q.delete();
        exp_frame = 1'b0; exp_parity = 1'b0; exp_overrun = 1'b0;
        repeat (3) tick();
        chk("midreset_count", {27'd0, count}, 0);
        chk("midreset_rvalid", {31'd0, rvalid}, 0);
        rstn = 1'b1;
        repeat (1100) tick();
        idle(300);
        chk("post_reset_count", {27'd0, count}, 0);
        chk("post_reset_frame_err", {31'd0, frame_err}, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("post_reset_rx_count", {27'd0, count}, 1);
        drain("post_reset_drain");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
